// File: rtl/store_data_serializer.sv
// rtl/store_data_serializer.sv - serializes a 128-bit vector operand into word-aligned 32-bit store beats
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   start_i               launch a store (sampled only when idle)
//   wide_vs_i             source bytes, byte 0 stored first
//   base_addr_i           byte address of the first stored byte
//   sew_i, vl_i           element width code and element count
//   data_req_o/we_o       write request valid (we mirrors req)
//   data_addr_o           word address of the presented beat
//   data_be_o/wdata_o     byte enables and lane-aligned write data
//   data_gnt_i            beat accepted
//   data_rvalid_i         one write response per granted beat
//   busy_o, done_o        operation in progress, one-cycle completion pulse

module store_data_serializer (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [127:0] wide_vs_i,
    input  logic [31:0]  base_addr_i,
    input  logic [1:0]   sew_i,
    input  logic [4:0]   vl_i,
    output logic         data_req_o,
    output logic         data_we_o,
    output logic [31:0]  data_addr_o,
    output logic [3:0]   data_be_o,
    output logic [31:0]  data_wdata_o,
    input  logic         data_gnt_i,
    input  logic         data_rvalid_i,
    output logic         busy_o,
    output logic         done_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t         state_q, state_d;
    logic [127:0]   data_q;
    logic [31:0]    addr_q;
    logic [4:0]     ptr_q;
    logic [4:0]     total_q;
    logic [2:0]     cnt_q;

    logic [6:0]     vl_scaled;
    logic [4:0]     total_d;
    logic [1:0]     lane;
    logic [2:0]     room;
    logic [4:0]     remain;
    logic [2:0]     beat_n;
    logic [3:0]     beat_be;
    logic [31:0]    beat_wdata;
    logic           last_beat;
    logic           grant_fire;
    logic           rsp_fire;

    // Byte count of the request, clamped to the register width.
    always_comb begin
        case (sew_i)
            2'b00:   vl_scaled = {2'b00, vl_i};
            2'b01:   vl_scaled = {1'b0, vl_i, 1'b0};
            default: vl_scaled = {vl_i, 2'b00};
        endcase
        total_d = (vl_scaled > 7'd16) ? 5'd16 : vl_scaled[4:0];
    end

    // Current beat: n bytes starting at lane L, limited by the word edge and remaining bytes.
    always_comb begin
        lane       = addr_q[1:0];
        room       = 3'd4 - {1'b0, lane};
        remain     = total_q - ptr_q;
        beat_n     = (remain < {2'b00, room}) ? remain[2:0] : room;
        beat_be    = '0;
        beat_wdata = '0;
        for (int i = 0; i < 4; i++) begin
            beat_be[i] = (i >= int'(lane)) && (i < int'(lane) + int'(beat_n));
            for (int k = 0; k < 16; k++) begin
                if (beat_be[i] && (k == int'(ptr_q) + i - int'(lane))) begin
                    beat_wdata[8*i +: 8] = data_q[8*k +: 8];
                end
            end
        end
        last_beat = (ptr_q + {2'b00, beat_n}) >= total_q;
    end

    assign grant_fire = (state_q == S_REQ) && data_gnt_i;
    // Responses with nothing outstanding (e.g. after a mid-flight reset) are dropped.
    assign rsp_fire   = data_rvalid_i && (cnt_q != 3'd0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_i) state_d = (total_d == 5'd0) ? S_DONE : S_REQ;
            S_REQ:  if (grant_fire && last_beat) state_d = S_WAIT;
            S_WAIT: if (cnt_q == 3'd0) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q  <= '0;
            addr_q  <= '0;
            ptr_q   <= '0;
            total_q <= '0;
            cnt_q   <= '0;
        end else begin
            if (state_q == S_IDLE && start_i) begin
                data_q  <= wide_vs_i;
                addr_q  <= base_addr_i;
                ptr_q   <= '0;
                total_q <= total_d;
            end
            if (grant_fire) begin
                ptr_q  <= ptr_q + {2'b00, beat_n};
                addr_q <= addr_q + {29'd0, beat_n};
            end
            case ({grant_fire, rsp_fire})
                2'b10:   cnt_q <= cnt_q + 3'd1;
                2'b01:   cnt_q <= cnt_q - 3'd1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Outputs depend only on registered state, so they stay put while a beat is stalled.
    always_comb begin
        data_req_o   = 1'b0;
        data_addr_o  = '0;
        data_be_o    = '0;
        data_wdata_o = '0;
        if (state_q == S_REQ) begin
            data_req_o   = 1'b1;
            data_addr_o  = {addr_q[31:2], 2'b00};
            data_be_o    = beat_be;
            data_wdata_o = beat_wdata;
        end
        data_we_o = data_req_o;
        busy_o    = (state_q != S_IDLE);
        done_o    = (state_q == S_DONE);
    end

endmodule

// File: doc/store_data_serializer.md
# store_data_serializer

Store-path counterpart of the load byte-gathering register. Accepts a 128-bit vector source operand plus base address, element width and vector length, then serializes the packed bytes into word-aligned 32-bit memory write transactions with per-byte enables. It sits between the vector register file read port and the data memory request/grant/response interface. It handles arbitrary base-address byte misalignment.

## Interface
- Parameters: none; register width fixed at 128 bits (16 bytes).
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock, synchronous, active-high
- start_i  in  1  launch store; sampled only in IDLE
- wide_vs_i  in  128  source bytes; byte k = wide_vs_i[8k+7:8k], byte 0 stored first
- base_addr_i  in  32  byte address of first stored byte
- sew_i  in  2  element width: 00=8b, 01=16b, 10=32b, 11 treated as 32b
- vl_i  in  5  element count, 0..16
- data_req_o  out  1  write request valid
- data_we_o  out  1  write enable; equals data_req_o
- data_addr_o  out  32  word address, bits [1:0] always 00
- data_be_o  out  4  byte enables
- data_wdata_o  out  32  write data, byte lane i = bits [8i+7:8i]
- data_gnt_i  in  1  request accepted
- data_rvalid_i  in  1  write response, one per granted beat, at least 1 cycle after its grant
- busy_o  out  1  operation in progress
- done_o  out  1  one-cycle completion pulse

## Operation
- On start_i in IDLE: capture wide_vs_i, base_addr_i; total bytes T = min(vl_i << sew, 16); byte pointer P = 0; current address A = base_addr_i; outstanding count C = 0.
- States: IDLE, REQ, WAIT, DONE.
  - IDLE -> REQ on start_i with T>0; IDLE -> DONE on start_i with T=0 (no requests issued).
  - REQ: present beat; on data_gnt_i advance; after the granted beat is the last one -> WAIT.
  - WAIT -> DONE when C==0 (including the case where C is already 0 on entry).
  - DONE -> IDLE unconditionally.
- Beat formation: lane L = A[1:0]; n = min(4-L, T-P). data_addr_o = {A[31:2],2'b00}; data_be_o has n ones starting at bit L; lane L+j carries captured byte P+j for j<n; unenabled lanes drive 0.
- On grant: P += n; A += n (next A word-aligned); C += 1.
- C: +1 on grant, -1 on rvalid, unchanged if both in the same cycle. C is 3 bits. An rvalid when C==0 is ignored (no underflow).
- start_i outside IDLE is ignored; captured data are not disturbed.
- Max 5 beats (16 bytes, misaligned).

## Timing
- Reset values: data_req_o 0, data_we_o 0, data_addr_o 0, data_be_o 0, data_wdata_o 0, busy_o 0, done_o 0; state IDLE, C 0.
- start_i at cycle N -> data_req_o=1 with beat 0 at N+1; busy_o=1 from N+1 through the DONE cycle inclusive.
- Request outputs are registered and held stable while data_req_o=1 and data_gnt_i=0.
- Grant at cycle M for a non-last beat -> next beat is presented at M+1 with data_req_o still high (back-to-back).
- Grant of the last beat at M -> data_req_o=0, data_be_o=0 at M+1.
- Last outstanding rvalid at cycle R (all beats granted) -> WAIT sees C==0 at R+1; DONE at R+2 with done_o=1; IDLE at R+3.
- T=0: start at N -> done_o=1 at N+1, data_req_o never asserted.
- Reset mid-operation: all outputs and state return to reset values on the next edge. Later rvalids are ignored.

## Test plan
- Aligned: base 0x1000, sew=10, vl=4, wide_vs=0x44444444_33333333_22222222_11111111 -> 4 beats, addr 0x1000/0x1004/0x1008/0x100C, be 1111, wdata 0x11111111..0x44444444, gnt every cycle gives consecutive beats; done_o 2 cycles after the 4th rvalid.
- Misaligned bytes: base 0x2003, sew=00, vl=6, bytes 0..5 = 0x11..0x66 -> (0x2000, be 1000, 0x11000000), (0x2004, be 1111, 0x55443322), (0x2008, be 0001, 0x00000066).
- Misaligned full register: base 0x3002, sew=01, vl=8 -> 5 beats: 0x3000 be 1100, 0x3004/0x3008/0x300C be 1111, 0x3010 be 0011.
- Grant stall: hold data_gnt_i low 3 cycles on beat 1 -> addr/be/wdata/req unchanged across the stall. Also assert rvalid and gnt in the same cycle -> C unchanged, completion still correct.
- vl=0 start at N -> done_o=1 at N+1, no data_req_o. Also start_i while busy -> ignored, and the original transfer completes unaltered.
- Reset asserted mid-REQ after beat 1 granted -> all outputs 0 next cycle. A stray rvalid afterwards -> no done_o. A new start then runs correctly.
